// File: rtl/fetch.sv
// -----------------------------------------------------------------------------
// fetch: instruction fetch unit for the single-issue MIPS core.
//
// Reads one instruction word at a time from instruction memory over a req/ack
// handshake and holds it in an instruction register (IR). The IR and its
// decoded fields go to the decode/control stage under a valid/ready handshake.
// At accept time the control stage's branch decision (pc_load_i) selects the
// next PC. An external redirect restarts fetch from any state.
//
// Handshakes:
//   imem: imem_req_o is high for the whole FETCH state. imem_addr_o holds
//         steady until imem_ack_i, unless a redirect abandons the request.
//         imem_ack_i qualifies imem_data_i in the same cycle. An ack in the
//         first request cycle is legal.
//   instr: instr_valid_o stays high until instr_valid_o & instr_ready_i.
//         While it is high, instr_o, pc_o and the derived fields stay stable.
//
// Ports:
//   clk_i, rst_i           clock (rising edge), async active-high reset
//   imem_req_o/addr_o      read request and word address (= PC)
//   imem_ack_i/data_i      read complete and returned instruction word
//   instr_valid_o/ready_i  IR holds an unconsumed instruction / decode accepts
//   instr_o, opcode_o, funct_o, imm_o  IR and its fields (imm sign-extended)
//   pc_o                   PC of the instruction in instr_o
//   pc_load_i              branch taken, used only in the accept cycle
//   redirect_i/redirect_pc_i  restart fetch at redirect_pc_i (bits [1:0] := 0)
// -----------------------------------------------------------------------------
module fetch #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    output logic                  imem_req_o,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    input  logic                  imem_ack_i,
    input  logic [31:0]           imem_data_i,
    output logic                  instr_valid_o,
    input  logic                  instr_ready_i,
    output logic [31:0]           instr_o,
    output logic [5:0]            opcode_o,
    output logic [5:0]            funct_o,
    output logic [31:0]           imm_o,
    output logic [ADDR_WIDTH-1:0] pc_o,
    input  logic                  pc_load_i,
    input  logic                  redirect_i,
    input  logic [ADDR_WIDTH-1:0] redirect_pc_i
);

    localparam logic [0:0] STATE_FETCH = 1'b0;
    localparam logic [0:0] STATE_ISSUE = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] issue_pc_q, issue_pc_d;
    logic [31:0]           ir_q, ir_d;

    logic                  accept;
    logic [ADDR_WIDTH-1:0] pc_seq;
    logic [ADDR_WIDTH-1:0] br_off;
    logic [ADDR_WIDTH-1:0] redirect_target;

    // The low address bits of a redirect target are forced to zero.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

    assign redirect_target = {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};

    // Fields are plain wiring from the IR.
    assign instr_o  = ir_q;
    assign opcode_o = ir_q[31:26];
    assign funct_o  = ir_q[5:0];
    assign imm_o    = {{16{ir_q[15]}}, ir_q[15:0]};
    assign pc_o     = issue_pc_q;

    assign imem_req_o    = (state_q == STATE_FETCH);
    assign imem_addr_o   = pc_q;
    assign instr_valid_o = (state_q == STATE_ISSUE);
    assign accept        = instr_valid_o & instr_ready_i;

    // pc_q still holds the issued instruction's PC while in ISSUE, so the
    // branch target is computed from it. The sum wraps modulo 2^ADDR_WIDTH.
    assign pc_seq = pc_q + ADDR_WIDTH'(4);
    assign br_off = ADDR_WIDTH'($signed({imm_o[29:0], 2'b00}));

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        issue_pc_d = issue_pc_q;
        ir_d       = ir_q;
        if (redirect_i) begin
            // Redirect overrides a same-cycle ack (data dropped) and a
            // same-cycle accept (pc_load_i dropped).
            pc_d    = redirect_target;
            state_d = STATE_FETCH;
        end else begin
            case (state_q)
                STATE_FETCH: begin
                    if (imem_ack_i) begin
                        ir_d       = imem_data_i;
                        issue_pc_d = pc_q;
                        state_d    = STATE_ISSUE;
                    end
                end
                STATE_ISSUE: begin
                    if (accept) begin
                        pc_d    = pc_load_i ? (pc_seq + br_off) : pc_seq;
                        state_d = STATE_FETCH;
                    end
                end
                default: state_d = STATE_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= STATE_FETCH;
            pc_q       <= RESET_PC;
            issue_pc_q <= RESET_PC;
            ir_q       <= 32'h0000_0000;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            issue_pc_q <= issue_pc_d;
            ir_q       <= ir_d;
        end
    end

endmodule

// File: doc/fetch.md
Name: fetch

Overview:
- Instruction fetch unit for the single-issue MIPS core.
- Issues word reads to instruction memory over a req/ack handshake and holds each returned instruction in an instruction register.
- Presents opcode/funct/immediate fields to the decode/control stage under a valid/ready handshake.
- Consumes the control stage's branch-taken (pc_load) decision to select the next PC; also supports an external redirect.

Parameters:
- ADDR_WIDTH, 32, width of PC and instruction memory address.
- RESET_PC, 0, PC loaded on reset; must be word aligned.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- imem_req_o  out  1  read request to instruction memory.
- imem_addr_o  out  ADDR_WIDTH  read address, equals PC.
- imem_ack_i  in  1  read complete; imem_data_i is valid this cycle.
- imem_data_i  in  32  instruction word.
- instr_valid_o  out  1  instruction register holds an unconsumed instruction.
- instr_ready_i  in  1  decode/control accepts the instruction.
- instr_o  out  32  full instruction register.
- opcode_o  out  6  instr[31:26].
- funct_o  out  6  instr[5:0].
- imm_o  out  32  sign-extended instr[15:0].
- pc_o  out  ADDR_WIDTH  PC of the instruction in instr_o.
- pc_load_i  in  1  branch taken; sampled only on the accept cycle.
- redirect_i  in  1  restart fetch at redirect_pc_i.
- redirect_pc_i  in  ADDR_WIDTH  redirect target; bits [1:0] ignored (forced 0).

Behaviour:
- States:
  - FETCH: request outstanding.
  - ISSUE: instruction held, waiting for accept.
- Reset (async, any state):
  - state=FETCH, pc=RESET_PC, instruction register=0 (decodes as R-type SLL, a nop).
  - instr_valid_o=0.
  - imem_req_o is combinational from state, so it is 1 during and after reset.
- FETCH:
  - imem_req_o=1 and imem_addr_o=pc, held stable until imem_ack_i.
  - On ack: IR<=imem_data_i, pc_o<=pc, state->ISSUE.
  - Ack latency is unbounded; ack in the same cycle as the request is legal.
- ISSUE:
  - imem_req_o=0, instr_valid_o=1.
  - instr_o and all derived fields are stable until accept.
  - Accept = instr_valid_o & instr_ready_i.
  - On accept: pc <= pc_load_i ? pc+4+(imm_o<<2) : pc+4, truncated to ADDR_WIDTH (mod 2^ADDR_WIDTH wrap); state->FETCH.
  - pc_load_i is ignored on any cycle other than accept.
- Throughput: the minimum is 2 cycles per instruction (ack on the first FETCH cycle, ready on the first ISSUE cycle).
- Redirect (highest priority, any state):
  - pc <= {redirect_pc_i[ADDR_WIDTH-1:2],2'b00}; state->FETCH; instr_valid_o deasserts next cycle.
  - In FETCH with a same-cycle ack: returned data is discarded and the IR is not updated.
  - In ISSUE with a same-cycle accept: pc_load_i is ignored and the redirect target wins. The accept still counts as consumed by decode.
  - Memory must tolerate a request abandoned after the redirect, i.e. the address changing while req stays high.
- Single outstanding request; no prefetch buffering.
- Fields: opcode_o, funct_o and imm_o are pure wiring from the IR. imm_o = {{16{instr[15]}},instr[15:0]}.
- Mid-operation reset: an ack arriving after reset deassertion belongs to the new RESET_PC request; the memory must not deliver a stale ack.

Test Plan:
- Reset, then ack every cycle with data 0x00221820 (add), ready=1 -> addresses 0,4,8,... requested; opcode_o=0, funct_o=0x20 on each issue; one instruction per 2 cycles.
- Ack delayed 3 cycles -> imem_req_o stays 1 and imem_addr_o stays constant for all 4 cycles; instr_valid_o=0 until the cycle after ack.
- BEQ 0x1022FFFF at pc=0x10, accepted with pc_load_i=1 -> next imem_addr_o=0x10. Same instruction with pc_load_i=0 -> next imem_addr_o=0x14.
- ready held 0 for 5 cycles in ISSUE while pc_load_i toggles -> instr_o, pc_o and instr_valid_o stable; no new request; the branch uses pc_load_i only from the accept cycle.
- redirect_i with redirect_pc_i=0x103 in the same cycle as imem_ack_i -> IR unchanged, next imem_addr_o=0x100, instr_valid_o=0.
- rst_i pulsed asynchronously mid-ISSUE at pc=0x40 -> instr_valid_o=0 immediately; imem_addr_o=RESET_PC. Also, pc=0xFFFFFFFC accepted with no branch -> next address 0x0 (wrap).
